// File: rtl/pc_redirect_sequencer_pkg.sv
// Shared types and constants for the PC redirect sequencer.
package mips_pc_pkg;

    typedef enum logic [1:0] {
        PC_RUN,
        PC_DELAY,
        PC_HALTED
    } pc_state_t;

    localparam logic [31:0] PC_STEP              = 32'd4;
    localparam logic [31:0] PC_RESET_VECTOR_DEF  = 32'hBFC0_0000;
    localparam logic [31:0] PC_HALT_ADDR_DEF     = 32'h0000_0000;

    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_sequencer_target_addr_holder.sv
// Holds the branch target captured on the accepting advance until the redirect.
module target_addr_holder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_enable,
    input  logic [31:0] tgt_addr_0,
    output logic [31:0] tgt_addr
);

    logic [31:0] r_tgt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tgt <= 32'd0;
        else if (clk_enable)
            r_tgt <= tgt_addr_0;
    end

    assign tgt_addr = r_tgt;

endmodule

// File: rtl/pc_redirect_sequencer.sv
// Program counter owner: one delay slot after a taken branch, then redirect; halts on HALT_ADDR.
// Optional redirect counter output enabled by defining PC_REDIRECT_COUNT_EN.
module pc_redirect_sequencer
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR_DEF,
    parameter logic [31:0] HALT_ADDR    = PC_HALT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_enable,
    output logic        pc_valid,
    output logic [31:0] pc,
    input  logic        pc_ready,
    input  logic        branch_req,
    input  logic [31:0] branch_tgt,
    output logic        halted,
    output logic        slot_branch_err,
`ifdef PC_REDIRECT_COUNT_EN
    output logic        align_err,
    output logic [31:0] redirect_count
`else
    output logic        align_err
`endif
);

    pc_state_t   r_state, w_next_state;
    logic [31:0] r_pc;
    logic        r_slot_err, r_align_err;
    logic        w_advance, w_capture;
    logic [31:0] w_tgt;

    assign w_advance = clk_enable & pc_valid & pc_ready;
    assign w_capture = w_advance & branch_req & (r_state == PC_RUN);

    target_addr_holder u_tgt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_enable (w_capture),
        .tgt_addr_0 (pc_align(branch_tgt)),
        .tgt_addr   (w_tgt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= PC_RUN;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            PC_RUN:    if (w_advance && branch_req) w_next_state = PC_DELAY;
            PC_DELAY:  if (w_advance) w_next_state = (w_tgt == HALT_ADDR) ? PC_HALTED : PC_RUN;
            PC_HALTED: w_next_state = PC_HALTED;
            default:   w_next_state = PC_RUN;
        endcase
    end

    always_comb begin
        pc_valid = (r_state != PC_HALTED);
        halted   = (r_state == PC_HALTED);
    end

    // In DELAY the slot instruction's branch_req is never a redirect, only an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_VECTOR;
            r_slot_err  <= 1'b0;
            r_align_err <= 1'b0;
        end else if (w_advance) begin
            if (r_state == PC_DELAY) begin
                r_pc <= w_tgt;
                if (branch_req) r_slot_err <= 1'b1;
            end else begin
                r_pc <= r_pc + PC_STEP;
                if (branch_req && (branch_tgt[1:0] != 2'b00)) r_align_err <= 1'b1;
            end
        end
    end

    assign pc              = r_pc;
    assign slot_branch_err = r_slot_err;
    assign align_err       = r_align_err;

`ifdef PC_REDIRECT_COUNT_EN
    logic [31:0] r_redirect_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_redirect_count <= 32'd0;
        else if (w_advance && (r_state == PC_DELAY))
            r_redirect_count <= r_redirect_count + 32'd1;
    end

    assign redirect_count = r_redirect_count;
`endif

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Directed bench for pc_redirect_sequencer with a queue-based reference model.
module tb_pc_redirect_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_enable;
    logic        pc_valid;
    logic [31:0] pc;
    logic        pc_ready;
    logic        branch_req;
    logic [31:0] branch_tgt;
    logic        halted;
    logic        slot_branch_err;
    logic        align_err;
`ifdef PC_REDIRECT_COUNT_EN
    logic [31:0] redirect_count;
`endif

    int total = 0;
    int bad   = 0;

    pc_redirect_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_enable      (clk_enable),
        .pc_valid        (pc_valid),
        .pc              (pc),
        .pc_ready        (pc_ready),
        .branch_req      (branch_req),
        .branch_tgt      (branch_tgt),
        .halted          (halted),
        .slot_branch_err (slot_branch_err),
`ifdef PC_REDIRECT_COUNT_EN
        .align_err       (align_err),
        .redirect_count  (redirect_count)
`else
        .align_err       (align_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference: a queue of pending redirects; a non-empty queue means the
    // instruction now at pc is a delay slot.
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    logic        m_halt, m_serr, m_aerr;
    logic [31:0] m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc   = 32'hBFC0_0000;
            m_pend.delete();
            m_halt = 1'b0;
            m_serr = 1'b0;
            m_aerr = 1'b0;
            m_cnt  = 32'd0;
        end else if (clk_enable && pc_ready && !m_halt) begin
            if (m_pend.size() != 0) begin
                m_pc = m_pend.pop_front();
                m_cnt = m_cnt + 1;
                if (branch_req) m_serr = 1'b1;
                if (m_pc == 32'h0) m_halt = 1'b1;
            end else begin
                m_pc = m_pc + 32'd4;
                if (branch_req) begin
                    m_pend.push_back(branch_tgt & 32'hFFFF_FFFC);
                    if (branch_tgt % 4 != 0) m_aerr = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic ce, input logic rdy, input logic br, input logic [31:0] tgt);
        clk_enable = ce;
        pc_ready   = rdy;
        branch_req = br;
        branch_tgt = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        clk_enable = 1'b1;
        pc_ready   = 1'b1;
        branch_req = 1'b0;
        branch_tgt = 32'h0;

        fork
            forever begin
                @(negedge clk);
                chk("model_pc",       pc,              m_pc);
                chk("model_valid",    pc_valid,        !m_halt);
                chk("model_halted",   halted,          m_halt);
                chk("model_slot_err", slot_branch_err, m_serr);
                chk("model_align",    align_err,       m_aerr);
`ifdef PC_REDIRECT_COUNT_EN
                chk("model_count",    redirect_count,  m_cnt);
`endif
            end
        join_none

        @(posedge clk);
        #1;
        chk("rst_pc",    pc,       32'hBFC0_0000);
        chk("rst_valid", pc_valid, 1'b1);
        chk("rst_halt",  halted,   1'b0);
        rst_n = 1'b1;

        // sequential fetch
        cyc(1, 1, 0, 0); chk("seq1", pc, 32'hBFC0_0004);
        cyc(1, 1, 0, 0); chk("seq2", pc, 32'hBFC0_0008);
        cyc(1, 1, 0, 0); chk("seq3", pc, 32'hBFC0_000C);

        // delay slot then redirect
        do_reset();
        cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 32'hBFC0_0100); chk("slot_pc",  pc, 32'hBFC0_0008);
        cyc(1, 1, 0, $urandom);      chk("redir_pc", pc, 32'hBFC0_0100);

        // same with stalls and target churn after capture
        do_reset();
        cyc(1, 1, 0, 0);
        cyc(0, 1, 1, 32'h1234_5678); chk("stall_ce", pc, 32'hBFC0_0004);
        cyc(1, 0, 1, 32'h1234_5678); chk("stall_rdy", pc, 32'hBFC0_0004);
        cyc(1, 1, 1, 32'hBFC0_0100); chk("st_slot", pc, 32'hBFC0_0008);
        cyc(0, 1, 1, $urandom);
        cyc(1, 0, 1, $urandom);
        cyc(0, 0, 0, $urandom);      chk("st_hold", pc, 32'hBFC0_0008);
        chk("st_noerr", slot_branch_err, 1'b0);
        cyc(1, 1, 0, $urandom);      chk("st_redir", pc, 32'hBFC0_0100);

        // branch in the delay slot is ignored for redirection
        cyc(1, 1, 1, 32'hBFC0_0200); chk("err_slot", pc, 32'hBFC0_0104);
        cyc(1, 1, 1, 32'hBFC0_0300); chk("err_redir", pc, 32'hBFC0_0200);
        chk("err_serr", slot_branch_err, 1'b1);

        // misaligned target is aligned down
        cyc(1, 1, 1, 32'hBFC0_0102); chk("al_flag", align_err, 1'b1);
        cyc(1, 1, 0, 0);             chk("al_pc", pc, 32'hBFC0_0100);

        // halt
        cyc(1, 1, 1, 32'h0);         chk("h_slot", pc, 32'hBFC0_0104);
        cyc(1, 1, 0, 0);
        chk("h_pc", pc, 32'h0); chk("h_halt", halted, 1'b1); chk("h_valid", pc_valid, 1'b0);
        cyc(1, 1, 1, 32'h40);
        cyc(1, 1, 0, 0);
        chk("h_stay_pc", pc, 32'h0); chk("h_stay", halted, 1'b1);
`ifdef PC_REDIRECT_COUNT_EN
        chk("cnt_total", redirect_count, 32'd4);
`endif

        // pc wrap does not halt
        do_reset();
        cyc(1, 1, 1, 32'hFFFF_FFFC);
        cyc(1, 1, 0, 0);             chk("wrap_at", pc, 32'hFFFF_FFFC);
        cyc(1, 1, 0, 0);
        chk("wrap_pc", pc, 32'h0); chk("wrap_nohalt", halted, 1'b0);

        // async reset while in DELAY, after one completed redirect
        do_reset();
        cyc(1, 1, 1, 32'hBFC0_0100);
        cyc(1, 1, 0, 0);
`ifdef PC_REDIRECT_COUNT_EN
        chk("cnt_one", redirect_count, 32'd1);
`endif
        cyc(1, 1, 1, 32'hBFC0_0302);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_pc",   pc,              32'hBFC0_0000);
        chk("mid_serr", slot_branch_err, 1'b0);
        chk("mid_aerr", align_err,       1'b0);
        chk("mid_halt", halted,          1'b0);
`ifdef PC_REDIRECT_COUNT_EN
        chk("mid_cnt",  redirect_count,  32'd0);
`endif
        #1;
        rst_n = 1'b1;
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);             chk("post_rst", pc, 32'hBFC0_0008);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
